// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter
// Brief   : Shares one MREQ/WRITE/SIZE/ACK_n memory port between fetch and
//           load/store requesters, with starvation bound and ACK watchdog.
// Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int STARVE_MAX     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ready,
   output logic              i_err,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [1:0]        d_size,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              d_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_req,
   output logic              mem_write,
   output logic [1:0]        mem_size,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack_n
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [TW-1:0] C_TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [SW-1:0] C_STREAK_MAX = SW'(STARVE_MAX);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              owner_d_q, owner_d_d;     // 1 = data requester owns the port
   logic [SW-1:0]     streak_q, streak_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_write_q, mem_write_d;
   logic [1:0]        mem_size_q, mem_size_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic              i_ready_q, i_ready_d;
   logic              i_err_q, i_err_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              d_ready_q, d_ready_d;
   logic              d_err_q, d_err_d;

   logic              w_grant_d;
   logic              w_grant_i;
   logic [DATA_W-1:0] w_rdata_masked;

   assign w_grant_d = d_req && !(i_req && (streak_q == C_STREAK_MAX));
   assign w_grant_i = i_req && !w_grant_d;

   // Stores return zero; loads are zero-extended from the access size.
   always_comb begin
      w_rdata_masked = mem_rdata;
      if (mem_write_q) begin
         w_rdata_masked = '0;
      end else begin
         case (mem_size_q)
            2'b00:   w_rdata_masked = mem_rdata;
            2'b01:   w_rdata_masked = {{(DATA_W-16){1'b0}}, mem_rdata[15:0]};
            default: w_rdata_masked = {{(DATA_W-8){1'b0}}, mem_rdata[7:0]};
         endcase
      end
   end

   always_comb begin
      state_d     = state_q;
      owner_d_d   = owner_d_q;
      streak_d    = streak_q;
      tmo_d       = tmo_q;
      mem_req_d   = mem_req_q;
      mem_write_d = mem_write_q;
      mem_size_d  = mem_size_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      i_ready_d   = 1'b0;
      i_err_d     = 1'b0;
      d_ready_d   = 1'b0;
      d_err_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (w_grant_d || w_grant_i) begin
               state_d   = S_BUSY;
               mem_req_d = 1'b1;
               tmo_d     = '0;
               owner_d_d = w_grant_d;
               if (w_grant_d) begin
                  mem_write_d = d_we;
                  mem_size_d  = d_size;
                  mem_addr_d  = d_addr;
                  mem_wdata_d = d_wdata;
                  if (!i_req)
                     streak_d = '0;
                  else if (streak_q != C_STREAK_MAX)
                     streak_d = streak_q + SW'(1);
               end else begin
                  mem_write_d = 1'b0;
                  mem_size_d  = 2'b00;
                  mem_addr_d  = i_addr;
                  mem_wdata_d = '0;
                  streak_d    = '0;
               end
            end
         end

         S_BUSY: begin
            // A same-edge ACK wins over the watchdog.
            if (!mem_ack_n || (tmo_q == C_TMO_LAST)) begin
               state_d     = S_DONE;
               mem_req_d   = 1'b0;
               mem_write_d = 1'b0;
               tmo_d       = '0;
               if (owner_d_q) begin
                  d_ready_d = 1'b1;
                  d_err_d   = mem_ack_n;
                  d_rdata_d = mem_ack_n ? '0 : w_rdata_masked;
               end else begin
                  i_ready_d = 1'b1;
                  i_err_d   = mem_ack_n;
                  i_rdata_d = mem_ack_n ? '0 : w_rdata_masked;
               end
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         owner_d_q   <= 1'b0;
         streak_q    <= '0;
         tmo_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_write_q <= 1'b0;
         mem_size_q  <= 2'b00;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_rdata_q   <= '0;
         i_ready_q   <= 1'b0;
         i_err_q     <= 1'b0;
         d_rdata_q   <= '0;
         d_ready_q   <= 1'b0;
         d_err_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_d_q   <= owner_d_d;
         streak_q    <= streak_d;
         tmo_q       <= tmo_d;
         mem_req_q   <= mem_req_d;
         mem_write_q <= mem_write_d;
         mem_size_q  <= mem_size_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         i_rdata_q   <= i_rdata_d;
         i_ready_q   <= i_ready_d;
         i_err_q     <= i_err_d;
         d_rdata_q   <= d_rdata_d;
         d_ready_q   <= d_ready_d;
         d_err_q     <= d_err_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_write = mem_write_q;
   assign mem_size  = mem_size_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign i_rdata   = i_rdata_q;
   assign i_ready   = i_ready_q;
   assign i_err     = i_err_q;
   assign d_rdata   = d_rdata_q;
   assign d_ready   = d_ready_q;
   assign d_err     = d_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_port_arbiter
// Brief   : Self-checking bench for mem_port_arbiter with a transaction model.
// Revision: 1.0
// ============================================================================
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;
   localparam int SM = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_rdata;
   logic          i_ready;
   logic          i_err;
   logic          d_req;
   logic          d_we;
   logic [1:0]    d_size;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_ready;
   logic          d_err;
   logic [AW-1:0] mem_addr;
   logic          mem_req;
   logic          mem_write;
   logic [1:0]    mem_size;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack_n;

   int errors = 0;
   int checks = 0;
   int streak_m = 0;
   int nwait = 1;
   logic [AW-1:0] last_addr = '0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .STARVE_MAX(SM)
   ) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready), .i_err(i_err),
      .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready), .d_err(d_err),
      .mem_addr(mem_addr), .mem_req(mem_req), .mem_write(mem_write), .mem_size(mem_size),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack_n(mem_ack_n)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   function automatic logic [31:0] exp_rdata(bit is_d, bit we, logic [1:0] sz,
                                             logic [31:0] v, bit tmo);
      if (tmo) return 32'h0;
      if (!is_d) return v;
      if (we) return 32'h0;
      if (sz == 2'b00) return v;
      if (sz == 2'b01) return v % 32'h10000;
      return v % 32'h100;
   endfunction

   task automatic new_d();
      d_req   = 1'b1;
      d_we    = 1'($urandom_range(0, 1));
      d_size  = 2'($urandom_range(0, 3));
      d_addr  = $urandom;
      d_wdata = $urandom;
   endtask

   task automatic new_i();
      i_req  = 1'b1;
      i_addr = $urandom;
   endtask

   // mode: 0 = randomise next requests, 1 = keep requests held, 2 = drop all
   task automatic run_slot(input int delay, input logic [31:0] rdv, input int mode);
      int          waited;
      int          busy;
      int          exp_busy;
      bit          got;
      bit          exp_d;
      bit          e_we;
      bit          tmo;
      logic [1:0]  e_size;
      logic [31:0] e_addr;
      logic [31:0] e_rd;
      exp_d  = d_req && !(i_req && (streak_m == SM));
      e_we   = d_we;
      e_size = d_size;
      e_addr = exp_d ? d_addr : i_addr;

      @(negedge clk);
      waited = 1;
      checks++;
      if (i_ready !== 1'b0 || d_ready !== 1'b0)
         $display("FAIL ready_pulse_width: got i=%b d=%b expected 0 0", i_ready, d_ready);
      if (nwait == 2) begin
         checks++;
         if (mem_addr !== last_addr)
            $display("FAIL mem_addr_hold: got %h expected %h", mem_addr, last_addr);
      end
      while (!mem_req && waited < 6) begin
         mem_ack_n = 1'($urandom_range(0, 1));
         @(negedge clk);
         waited++;
      end
      checks++;
      if (waited != nwait) begin
         $display("FAIL grant_latency: got %0d expected %0d", waited, nwait);
         errors++;
      end
      if (!mem_req) begin
         mem_ack_n = 1'b1;
         nwait = 1;
         return;
      end

      checks++;
      if (mem_addr !== e_addr) begin
         $display("FAIL grant_addr: got %h expected %h", mem_addr, e_addr);
         errors++;
      end
      checks++;
      if (mem_write !== (exp_d && e_we) || mem_size !== (exp_d ? e_size : 2'b00)) begin
         $display("FAIL grant_ctrl: got w=%b s=%b expected w=%b s=%b",
                  mem_write, mem_size, exp_d && e_we, exp_d ? e_size : 2'b00);
         errors++;
      end
      if (exp_d && e_we) begin
         checks++;
         if (mem_wdata !== d_wdata) begin
            $display("FAIL grant_wdata: got %h expected %h", mem_wdata, d_wdata);
            errors++;
         end
      end
      last_addr = e_addr;
      if (exp_d) streak_m = i_req ? ((streak_m < SM) ? streak_m + 1 : SM) : 0;
      else       streak_m = 0;

      busy = 0;
      got  = 1'b0;
      while (!got && busy < TO + 2) begin
         if (busy == delay) begin
            mem_ack_n = 1'b0;
            mem_rdata = rdv;
         end else begin
            mem_ack_n = 1'b1;
            mem_rdata = $urandom;
         end
         @(negedge clk);
         busy++;
         if (i_ready || d_ready) got = 1'b1;
         else begin
            checks++;
            if (mem_req !== 1'b1) begin
               $display("FAIL mem_req_held: got %b expected 1 at busy %0d", mem_req, busy);
               errors++;
            end
         end
      end
      mem_ack_n = 1'($urandom_range(0, 1));

      tmo      = (delay >= TO);
      exp_busy = tmo ? TO : delay + 1;
      e_rd     = exp_rdata(exp_d, e_we, e_size, rdv, tmo);
      checks++;
      if (busy != exp_busy) begin
         $display("FAIL access_cycles: got %0d expected %0d", busy, exp_busy);
         errors++;
      end
      checks++;
      if (d_ready !== exp_d || i_ready !== !exp_d) begin
         $display("FAIL ready_owner: got i=%b d=%b expected i=%b d=%b",
                  i_ready, d_ready, !exp_d, exp_d);
         errors++;
      end
      checks++;
      if ((exp_d ? d_err : i_err) !== tmo) begin
         $display("FAIL err_flag: got %b expected %b", exp_d ? d_err : i_err, tmo);
         errors++;
      end
      checks++;
      if ((exp_d ? d_rdata : i_rdata) !== e_rd) begin
         $display("FAIL rdata: got %h expected %h", exp_d ? d_rdata : i_rdata, e_rd);
         errors++;
      end
      checks++;
      if (mem_req !== 1'b0 || mem_write !== 1'b0) begin
         $display("FAIL done_release: got req=%b wr=%b expected 0 0", mem_req, mem_write);
         errors++;
      end

      nwait = 2;
      if (mode == 2) begin
         i_req = 1'b0;
         d_req = 1'b0;
      end else if (mode == 0) begin
         if (exp_d) begin
            if ($urandom_range(0, 1) != 0) new_d(); else d_req = 1'b0;
         end else begin
            if ($urandom_range(0, 1) != 0) new_i(); else i_req = 1'b0;
         end
         if (!i_req && $urandom_range(0, 2) == 0) new_i();
         if (!d_req && $urandom_range(0, 2) == 0) new_d();
         if (!i_req && !d_req) new_d();
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         checks++;
         if (mem_req !== 1'b0) begin
            $display("FAIL idle_no_req: got %b expected 0", mem_req);
            errors++;
         end
      end
      nwait = 1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      i_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_size = 2'b01;
      i_addr = 32'h1234; d_addr = 32'h5678; d_wdata = 32'hFFFF_FFFF;
      mem_ack_n = 1'b0; mem_rdata = 32'hDEAD_BEEF;
      repeat (3) @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || mem_write !== 1'b0 || mem_size !== 2'b00) begin
         $display("FAIL reset_ctrl: got req=%b wr=%b sz=%b expected 0 0 00",
                  mem_req, mem_write, mem_size);
         errors++;
      end
      checks++;
      if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
         $display("FAIL reset_bus: got addr=%h wdata=%h expected 0 0", mem_addr, mem_wdata);
         errors++;
      end
      checks++;
      if ({i_ready, i_err, d_ready, d_err} !== 4'b0000) begin
         $display("FAIL reset_flags: got %b expected 0000", {i_ready, i_err, d_ready, d_err});
         errors++;
      end
      checks++;
      if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
         $display("FAIL reset_rdata: got i=%h d=%h expected 0 0", i_rdata, d_rdata);
         errors++;
      end
      i_req = 1'b0; d_req = 1'b0; mem_ack_n = 1'b1;
      rst = 1'b0;
      streak_m = 0;
      idle_cycles(2);
   endtask

   task automatic test_fetch();
      i_req = 1'b1; i_addr = 32'h100;
      run_slot(0, 32'h1234_5678, 2);
   endtask

   task automatic test_sizes();
      d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h200; d_wdata = 32'h0;
      run_slot(0, 32'hAABB_CCDD, 2);
      checks++;
      if (d_rdata !== 32'h0000_00DD) begin
         $display("FAIL byte_load: got %h expected 000000dd", d_rdata);
         errors++;
      end
      d_req = 1'b1; d_we = 1'b0; d_size = 2'b01; d_addr = 32'h204;
      run_slot(1, 32'hAABB_CCDD, 2);
      checks++;
      if (d_rdata !== 32'h0000_CCDD) begin
         $display("FAIL half_load: got %h expected 0000ccdd", d_rdata);
         errors++;
      end
      d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 32'hF000_0000; d_wdata = 32'h41;
      run_slot(0, 32'h5555_5555, 2);
   endtask

   task automatic test_contention();
      bit order [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      i_req = 1'b1; i_addr = 32'h1000;
      d_req = 1'b1; d_we = 1'b0; d_size = 2'b00; d_addr = 32'h2000;
      for (int k = 0; k < 10; k++) begin
         run_slot(0, $urandom, 1);
         checks++;
         if (last_addr !== (order[k] ? 32'h2000 : 32'h1000) || mem_addr !== last_addr) begin
            $display("FAIL grant_order[%0d]: got %h expected %h", k, mem_addr,
                     order[k] ? 32'h2000 : 32'h1000);
            errors++;
         end
      end
      i_req = 1'b0; d_req = 1'b0;
   endtask

   task automatic test_timeout();
      d_req = 1'b1; d_we = 1'b0; d_size = 2'b00; d_addr = 32'h300;
      run_slot(TO + 10, 32'hCAFE_F00D, 2);
      i_req = 1'b1; i_addr = 32'h400;
      run_slot(2, 32'h0BAD_F00D, 2);
      d_req = 1'b1; d_we = 1'b0; d_size = 2'b00; d_addr = 32'h500;
      run_slot(TO - 1, 32'h7777_8888, 2);
   endtask

   task automatic test_reset_mid();
      idle_cycles(1);
      i_req = 1'b1; i_addr = 32'h1000;
      d_req = 1'b1; d_we = 1'b0; d_size = 2'b00; d_addr = 32'h2000;
      run_slot(0, $urandom, 1);
      run_slot(0, $urandom, 1);
      mem_ack_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h2000) begin
         $display("FAIL mid_grant: got req=%b addr=%h expected 1 00002000", mem_req, mem_addr);
         errors++;
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || i_ready !== 1'b0 || d_ready !== 1'b0) begin
         $display("FAIL mid_reset: got req=%b i=%b d=%b expected 0 0 0", mem_req, i_ready, d_ready);
         errors++;
      end
      rst = 1'b0;
      i_req = 1'b0; d_req = 1'b0;
      streak_m = 0;
      mem_ack_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (mem_req !== 1'b0 || i_ready !== 1'b0 || d_ready !== 1'b0) begin
            $display("FAIL late_ack: got req=%b i=%b d=%b expected 0 0 0",
                     mem_req, i_ready, d_ready);
            errors++;
         end
      end
      mem_ack_n = 1'b1;
      i_req = 1'b1; d_req = 1'b1;
      nwait = 1;
      for (int k = 0; k < 5; k++) run_slot(0, $urandom, 1);
      checks++;
      if (last_addr !== 32'h1000) begin
         $display("FAIL streak_after_reset: got %h expected 00001000", last_addr);
         errors++;
      end
      i_req = 1'b0; d_req = 1'b0;
   endtask

   task automatic test_random();
      int r;
      int dly;
      idle_cycles(1);
      new_d();
      new_i();
      for (int k = 0; k < 40; k++) begin
         r   = $urandom_range(0, 9);
         dly = (r < 7) ? (r % 4) : ((r == 7) ? TO - 1 : TO + 3);
         run_slot(dly, $urandom, 0);
      end
      i_req = 1'b0; d_req = 1'b0;
      idle_cycles(2);
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_sizes();
      test_contention();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
